snn_wb_responder: RTL and testbench

Wishbone classic slave responder for the SNN user project. It decodes host (management SoC) cycles, generates ack/read data, and holds the per-neuron weight and membrane-potential register file plus the shared neuron parameters. On a START command, a sequencer updates every neuron once, one neuron per cycle. It latches the spike vector and flags completion.

---
 rtl/snn_pkg.sv | 25 ++
 rtl/snn_neuron_update.sv | 29 ++
 rtl/snn_wb_responder.sv | 202 ++++++++++++++++++++
 tb/tb_snn_wb_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN Wishbone responder.
package snn_pkg;

   localparam int unsigned VmemW      = 8;
   localparam int unsigned MaxNeurons = 32;

   localparam logic [7:0] OffCtrl       = 8'h00;
   localparam logic [7:0] OffParam      = 8'h04;
   localparam logic [7:0] OffSpikes     = 8'h08;
   localparam logic [7:0] OffStepcnt    = 8'h0C;
   localparam logic [7:0] OffWeightBase = 8'h40;
   localparam logic [7:0] OffVmemBase   = 8'h80;

   localparam int unsigned CtrlStartBit = 0;
   localparam int unsigned CtrlModeBit  = 1;
   localparam int unsigned CtrlIrqEnBit = 2;
   localparam int unsigned CtrlBusyBit  = 8;

   typedef enum logic [1:0] {
      StIdle,
      StUpdate,
      StDone
   } state_e;

endpackage

// File: rtl/snn_neuron_update.sv
// Combinational leaky integrate-and-fire update for one neuron, with saturation at 255.
module snn_neuron_update
   import snn_pkg::*;
(
   input  logic [VmemW-1:0] v_mem_i,
   input  logic [VmemW-1:0] weight_i,
   input  logic [VmemW-1:0] beta_i,
   input  logic [VmemW-1:0] v_th_i,
   input  logic             mode_i,
   output logic [VmemW-1:0] v_next_o,
   output logic             spike_o
);

   logic [15:0]      prod;
   logic [16:0]      v_sum;
   logic [VmemW-1:0] v_sat;

   always_comb begin
      prod     = {8'd0, v_mem_i} * {8'd0, beta_i};
      v_sum    = 17'(prod >> 8) + {9'd0, weight_i};
      v_sat    = (v_sum > 17'd255) ? 8'hFF : v_sum[7:0];
      spike_o  = (v_sat >= v_th_i);
      v_next_o = v_sat;
      if (spike_o) begin
         v_next_o = mode_i ? (v_sat - v_th_i) : 8'd0;
      end
   end

endmodule

// File: rtl/snn_wb_responder.sv
// Wishbone classic slave holding the SNN register file and the per-step neuron sequencer.
// Optional macro SNN_IRQ_EN adds CTRL[2] IRQ_EN and a one-cycle irq_o pulse on step completion.
module snn_wb_responder
   import snn_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_dat_i,
   input  logic [31:0]            wbs_adr_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   output logic                   busy_o,
   output logic [NUM_NEURONS-1:0] spikes_o,
   output logic                   irq_o
);

   state_e                 state_q, state_d;
   logic [4:0]             idx_q, idx_d;
   logic [VmemW-1:0]       vmem_q [MaxNeurons];
   logic [VmemW-1:0]       vmem_d [MaxNeurons];
   logic [VmemW-1:0]       weight_q [MaxNeurons];
   logic [VmemW-1:0]       weight_d [MaxNeurons];
   logic [VmemW-1:0]       beta_q, beta_d;
   logic [VmemW-1:0]       vth_q, vth_d;
   logic                   mode_q, mode_d;
   logic [NUM_NEURONS-1:0] spikes_q, spikes_d;
   logic [NUM_NEURONS-1:0] pending_q, pending_d;
   logic [31:0]            stepcnt_q, stepcnt_d;
   logic                   ack_q, ack_d;
   logic [31:0]            dat_q, dat_d;

   logic             valid, req_new, wr_idle, ctrl_wr, busy, irq_en_rd;
   logic [7:0]       off_b;
   logic [4:0]       wt_idx, vm_idx;
   logic             wt_hit, vm_hit;
   logic [31:0]      rd_data;
   logic [VmemW-1:0] nu_v_next;
   logic             nu_spike;
   logic             unused_bits;

   // Low address bits and upper byte lanes carry no register content.
   assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

   assign valid   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req_new = valid & ~ack_q;
   assign busy    = (state_q != StIdle);
   // Writes commit in the ack cycle; anything arriving while busy is acked but dropped.
   assign wr_idle = ack_q & valid & wbs_we_i & ~busy;
   assign off_b   = {wbs_adr_i[7:2], 2'b00};
   assign ctrl_wr = wr_idle & (off_b == OffCtrl) & wbs_sel_i[0];

   // WEIGHT occupies 0x40-0x7F, so only the first 16 weights are host-addressable.
   assign wt_idx = {1'b0, wbs_adr_i[5:2]};
   assign vm_idx = wbs_adr_i[6:2];
   assign wt_hit = ((off_b & 8'hC0) == OffWeightBase) && (32'(wt_idx) < NUM_NEURONS);
   assign vm_hit = ((off_b & 8'h80) == OffVmemBase) && (32'(vm_idx) < NUM_NEURONS);

   snn_neuron_update u_neuron (
      .v_mem_i  (vmem_q[idx_q]),
      .weight_i (weight_q[idx_q]),
      .beta_i   (beta_q),
      .v_th_i   (vth_q),
      .mode_i   (mode_q),
      .v_next_o (nu_v_next),
      .spike_o  (nu_spike)
   );

   always_comb begin
      rd_data = '0;
      if (off_b == OffCtrl) begin
         rd_data[CtrlModeBit]  = mode_q;
         rd_data[CtrlIrqEnBit] = irq_en_rd;
         rd_data[CtrlBusyBit]  = busy;
      end else if (off_b == OffParam) begin
         rd_data[15:0] = {vth_q, beta_q};
      end else if (off_b == OffSpikes) begin
         rd_data[NUM_NEURONS-1:0] = spikes_q;
      end else if (off_b == OffStepcnt) begin
         rd_data = stepcnt_q;
      end else if (wt_hit) begin
         rd_data[VmemW-1:0] = weight_q[wt_idx];
      end else if (vm_hit) begin
         rd_data[VmemW-1:0] = vmem_q[vm_idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vmem_d    = vmem_q;
      weight_d  = weight_q;
      beta_d    = beta_q;
      vth_d     = vth_q;
      mode_d    = mode_q;
      spikes_d  = spikes_q;
      pending_d = pending_q;
      stepcnt_d = stepcnt_q;
      ack_d     = req_new;
      dat_d     = req_new ? rd_data : '0;

      if (wr_idle) begin
         if (off_b == OffParam) begin
            if (wbs_sel_i[0]) beta_d = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) vth_d  = wbs_dat_i[15:8];
         end
         if (ctrl_wr) begin
            mode_d = wbs_dat_i[CtrlModeBit];
            if (wbs_dat_i[CtrlStartBit]) begin
               state_d   = StUpdate;
               idx_d     = '0;
               pending_d = '0;
            end
         end
         if (wt_hit && wbs_sel_i[0]) weight_d[wt_idx] = wbs_dat_i[7:0];
         if (vm_hit && wbs_sel_i[0]) vmem_d[vm_idx] = wbs_dat_i[7:0];
      end

      case (state_q)
         StUpdate: begin
            vmem_d[idx_q] = nu_v_next;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
               if (idx_q == 5'(i)) pending_d[i] = nu_spike;
            end
            if (idx_q == 5'(NUM_NEURONS - 1)) begin
               // Publish on entry to DONE so spikes_o lands NUM_NEURONS+1 cycles after the ack.
               state_d  = StDone;
               spikes_d = pending_d;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         StDone: begin
            stepcnt_d = stepcnt_q + 32'd1;
            state_d   = StIdle;
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         vmem_q    <= '{default: '0};
         weight_q  <= '{default: '0};
         beta_q    <= '0;
         vth_q     <= '0;
         mode_q    <= 1'b0;
         spikes_q  <= '0;
         pending_q <= '0;
         stepcnt_q <= '0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         vmem_q    <= vmem_d;
         weight_q  <= weight_d;
         beta_q    <= beta_d;
         vth_q     <= vth_d;
         mode_q    <= mode_d;
         spikes_q  <= spikes_d;
         pending_q <= pending_d;
         stepcnt_q <= stepcnt_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

`ifdef SNN_IRQ_EN
   logic irq_en_q, irq_en_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (ctrl_wr) irq_en_d = wbs_dat_i[CtrlIrqEnBit];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) irq_en_q <= 1'b0;
      else          irq_en_q <= irq_en_d;
   end

   assign irq_en_rd = irq_en_q;
   assign irq_o     = irq_en_q & (state_q == StDone);
`else
   assign irq_en_rd = 1'b0;
   assign irq_o     = 1'b0;
`endif

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign busy_o    = busy;
   assign spikes_o  = spikes_q;

endmodule

// File: tb/tb_snn_wb_responder.sv
// Directed bench for snn_wb_responder with a step-level reference model of the register file.
module tb_snn_wb_responder;

   localparam int unsigned N    = 16;
   localparam logic [31:0] Base = 32'h3000_0000;
`ifdef SNN_IRQ_EN
   localparam bit IrqBuild = 1'b1;
`else
   localparam bit IrqBuild = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]    sel = '0;
   logic [31:0]   dat_i = '0, adr = '0;
   logic          ack;
   logic [31:0]   dat_o;
   logic          busy_o, irq_o;
   logic [N-1:0]  spikes_o;

   snn_wb_responder #(.NUM_NEURONS(N), .BASE_ADDR(Base)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .busy_o    (busy_o),
      .spikes_o  (spikes_o),
      .irq_o     (irq_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   // Reference model: whole-step semantics, timing expressed as cycle windows.
   int          m_vmem [N];
   int          m_wt [N];
   int          m_beta, m_vth, m_stepcnt;
   bit          m_mode, m_irq_en;
   int          busy_lo, busy_hi, spike_cycle;
   logic [N-1:0] pend_spikes, cur_spikes;
   bit          chk_on = 1'b0;
   int          busy_run = 0, last_run = 0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < N; i++) begin
         m_vmem[i] = 0;
         m_wt[i]   = 0;
      end
      m_beta = 0; m_vth = 0; m_stepcnt = 0; m_mode = 0; m_irq_en = 0;
      busy_lo = 1; busy_hi = 0; spike_cycle = -1;
      pend_spikes = '0; cur_spikes = '0;
   endfunction

   function automatic bit model_busy();
      return (cnt >= busy_lo) && (cnt <= busy_hi);
   endfunction

   function automatic void model_step();
      for (int i = 0; i < N; i++) begin
         int v;
         v = (m_vmem[i] * m_beta) / 256 + m_wt[i];
         if (v > 255) v = 255;
         pend_spikes[i] = (v >= m_vth);
         if (v >= m_vth) m_vmem[i] = m_mode ? v - m_vth : 0;
         else            m_vmem[i] = v;
      end
      m_stepcnt++;
   endfunction

   function automatic void model_write(logic [7:0] off, logic [31:0] d, logic [3:0] s);
      if (model_busy()) return;
      if (off == 8'h00 && s[0]) begin
         m_mode = d[1];
         if (IrqBuild) m_irq_en = d[2];
         if (d[0]) begin
            model_step();
            busy_lo = cnt + 1; busy_hi = cnt + N + 1; spike_cycle = cnt + N + 1;
         end
      end else if (off == 8'h04) begin
         if (s[0]) m_beta = int'(d[7:0]);
         if (s[1]) m_vth  = int'(d[15:8]);
      end else if (off >= 8'h40 && off < 8'h40 + 4 * N && s[0]) begin
         m_wt[(off - 8'h40) / 4] = int'(d[7:0]);
      end else if (off >= 8'h80 && off < 8'h80 + 4 * N && s[0]) begin
         m_vmem[(off - 8'h80) / 4] = int'(d[7:0]);
      end
   endfunction

   function automatic logic [31:0] model_read(logic [7:0] off);
      logic [31:0] r = '0;
      if (off == 8'h00) begin
         r[1] = m_mode; r[2] = m_irq_en; r[8] = model_busy();
      end else if (off == 8'h04) r = 32'((m_vth << 8) | m_beta);
      else if (off == 8'h08) r[N-1:0] = cur_spikes;
      else if (off == 8'h0C) r = 32'(m_stepcnt);
      else if (off >= 8'h40 && off < 8'h40 + 4 * N) r = 32'(m_wt[(off - 8'h40) / 4]);
      else if (off >= 8'h80 && off < 8'h80 + 4 * N) r = 32'(m_vmem[(off - 8'h80) / 4]);
      return r;
   endfunction

   // Per-cycle compare of the free-running outputs.
   always @(negedge clk) begin
      if (chk_on && !wb_rst_i) begin
         if (cnt == spike_cycle) cur_spikes = pend_spikes;
         check("busy_o", 32'(busy_o), 32'(model_busy()));
         check("spikes_o", 32'(spikes_o), 32'(cur_spikes));
         check("irq_o", 32'(irq_o), 32'(m_irq_en && cnt == spike_cycle));
         if (busy_o) busy_run++;
         else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
         end
      end else begin
         busy_run = 0;
      end
   end

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output bit acked);
      acked = 1'b0;
      rd    = '0;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ack) begin
            acked = 1'b1;
            rd    = dat_o;
            if (w) model_write({a[7:2], 2'b00}, d, s);
            break;
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (acked) begin
         @(negedge clk);
         check("ack_single_cycle", 32'(ack), 32'd0);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      bit acked;
      wb_xfer(1'b1, Base + 32'(off), d, s, rd, acked);
      check("write_ack", 32'(acked), 32'd1);
   endtask

   task automatic rd_chk(input logic [7:0] off, output logic [31:0] rd);
      bit acked;
      logic [31:0] exp;
      exp = model_read(off);
      wb_xfer(1'b0, Base + 32'(off), 32'd0, 4'hF, rd, acked);
      check("read_ack", 32'(acked), 32'd1);
      check("read_data", rd, exp);
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      check("idle_within_budget", 32'(n < 100), 32'd1);
   endtask

   // Reset is asserted for exactly one sampling edge from the current point in the cycle.
   task automatic do_reset();
      wb_rst_i = 1'b1;
      @(posedge clk); #1;
      wb_rst_i = 1'b0;
      model_clear();
   endtask

   task automatic start_step();
      wr(8'h00, {30'd0, m_mode, 1'b1}, 4'h1);
      wait_idle();
   endtask

   logic [31:0] r;
   bit          acked;

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      chk_on   = 1'b1;

      // Reset state and basic handshake.
      @(negedge clk);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_dat", dat_o, 32'd0);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_spikes", 32'(spikes_o), 32'd0);
      rd_chk(8'h04, r);
      check("param_after_reset", r, 32'd0);
      rd_chk(8'h3C, r);
      check("unmapped_read", r, 32'd0);
      wb_xfer(1'b0, Base + 32'h100, 32'd0, 4'hF, r, acked);
      check("out_of_window_no_ack", 32'(acked), 32'd0);

      // Byte lanes and unmapped writes.
      wr(8'h04, 32'h0000_BEEF, 4'b0010);
      rd_chk(8'h04, r);
      check("param_lane1_only", r, 32'h0000_BE00);
      wr(8'h3C, 32'hFFFF_FFFF, 4'hF);
      rd_chk(8'h3C, r);
      check("unmapped_write_dropped", r, 32'd0);

      // Leak/integrate, reset-to-zero mode.
      wr(8'h04, 32'h0000_6480, 4'b0011);
      wr(8'h40, 32'd60, 4'h1);
      wr(8'h80, 32'd0, 4'h1);
      wr(8'h00, 32'd0, 4'h1);
      start_step();
      rd_chk(8'h80, r);
      check("leak_step1_vmem0", r, 32'd60);
      check("leak_busy_cycles", 32'(last_run), 32'(N + 1));
      check("leak_step1_spike0", 32'(spikes_o[0]), 32'd0);
      start_step();
      rd_chk(8'h80, r);
      check("leak_step2_vmem0", r, 32'd90);
      check("leak_step2_spike0", 32'(spikes_o[0]), 32'd0);
      start_step();
      rd_chk(8'h80, r);
      check("leak_step3_vmem0", r, 32'd0);
      check("leak_step3_spike0", 32'(spikes_o[0]), 32'd1);
      rd_chk(8'h0C, r);
      check("leak_stepcnt", r, 32'd3);

      // Subtract-threshold mode.
      @(posedge clk); #1;
      do_reset();
      wr(8'h04, 32'h0000_6480, 4'b0011);
      wr(8'h40, 32'd60, 4'h1);
      wr(8'h00, 32'd2, 4'h1);
      repeat (3) start_step();
      rd_chk(8'h80, r);
      check("subtract_vmem0", r, 32'd5);
      check("subtract_spike0", 32'(spikes_o[0]), 32'd1);

      // Saturation, then v_th = 0.
      @(posedge clk); #1;
      do_reset();
      wr(8'h04, 32'h0000_FFFF, 4'b0011);
      wr(8'h44, 32'd255, 4'h1);
      wr(8'h84, 32'd255, 4'h1);
      start_step();
      rd_chk(8'h84, r);
      check("sat_vmem1", r, 32'd0);
      check("sat_spikes", 32'(spikes_o), 32'h0000_0002);
      wr(8'h04, 32'h0000_0000, 4'b0011);
      start_step();
      check("vth0_all_spike", 32'(spikes_o), 32'h0000_FFFF);

      // Busy protection.
      @(posedge clk); #1;
      do_reset();
      wr(8'h48, 32'd3, 4'h1);
      wr(8'h00, 32'd1, 4'h1);
      wr(8'h48, 32'd9, 4'h1);
      wr(8'h00, 32'd3, 4'h1);
      wait_idle();
      rd_chk(8'h48, r);
      check("busy_weight_kept", r, 32'd3);
      rd_chk(8'h0C, r);
      check("busy_single_step", r, 32'd1);
      rd_chk(8'h00, r);
      check("busy_mode_ignored", r, 32'd0);
      check("busy_cycles", 32'(last_run), 32'(N + 1));

      // Reset in the middle of a step (irq enabled where the build supports it).
      @(posedge clk); #1;
      do_reset();
      wr(8'h40, 32'd60, 4'h1);
      wr(8'h8C, 32'd77, 4'h1);
      wr(8'h00, 32'd4, 4'h1);
      rd_chk(8'h00, r);
      wr(8'h00, 32'd5, 4'h1);
      repeat (4) @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_spikes", 32'(spikes_o), 32'd0);
      rd_chk(8'h80, r);
      check("midrst_vmem0", r, 32'd0);
      rd_chk(8'h8C, r);
      check("midrst_vmem3", r, 32'd0);
      rd_chk(8'h0C, r);
      check("midrst_stepcnt", r, 32'd0);
      repeat (30) @(posedge clk);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
